glitch_seq_wb: RTL and testbench
================================

# glitch_seq_wb

Wishbone-slave glitch sequencer: the parametrised successor of the single-shot glitch register block. Holds delay, width, gap and pulse-count registers and runs an internal state machine that emits a train of N glitch-enable pulses after a programmable delay. The train starts on a software arm or on an external trigger edge. Sits between the Wishbone interconnect and the glitch clock core; `glitch_en_o` drives the core's enable.

## Interface
- `DELAY_W`, 16: delay counter width, 1..16.
- `WIDTH_W`, 8: pulse-width field width, 1..8.
- `GAP_W`, 8: inter-pulse gap field width, 1..8.
- `COUNT_W`, 8: pulse-count field width, 1..8.
- `clk_i`  in  1  sole clock; everything is synchronous to its rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `stb_i`  in  1  Wishbone strobe.
- `we_i`  in  1  write enable.
- `adr_i`  in  4  register address.
- `dat_i`  in  8  write data.
- `dat_o`  out  8  read data; valid while `ack_o`=1.
- `ack_o`  out  1  Wishbone acknowledge.
- `trig_i`  in  1  external trigger, asynchronous to `clk_i` when sync is compiled in.
- `glitch_en_o`  out  1  glitch enable pulse train.
- `ready_o`  out  1  high in IDLE.
- `busy_o`  out  1  high in DELAY, PULSE and GAP.
- `done_o`  out  1  one-cycle pulse when the last pulse of the train ends.

## Operation
- Register map (8-bit; fields zero-extended on read; excess write bits dropped):
  - 0 CTRL/STATUS
    - Write: bit0 ARM, bit1 ABORT, bit2 TRIG_EXT, bit3 TRIG_FALL. TRIG_EXT and TRIG_FALL are stored. ARM and ABORT self-clear.
    - Read: bit0 ready, bit1 armed, bit2 busy, bit3 done_sticky, bit4 TRIG_EXT, bit5 TRIG_FALL.
  - 1 WIDTH.
  - 2 DELAY[7:0].
  - 3 DELAY[15:8].
  - 4 GAP.
  - 5 COUNT.
  - 6 PULSES_DONE: read-only count of pulses emitted in the current or last train.
  - 7..15: reads return 0, writes ignored, both acked.
- A CTRL read clears done_sticky.
- While the FSM is not in IDLE, writes to addresses 1..5 and to the CTRL TRIG bits are acked but ignored. This keeps the train parameters stable.
- FSM states: IDLE, ARMED, DELAY, PULSE, GAP.
  - IDLE → ARMED on an ARM write when COUNT≠0. An ARM write with COUNT=0 is ignored. Entering ARMED clears PULSES_DONE and done_sticky.
  - ARMED → DELAY:
    - TRIG_EXT=0: after exactly one cycle in ARMED.
    - TRIG_EXT=1: on the cycle the selected trigger edge is detected (rising, or falling if TRIG_FALL=1). A level present at arm time is not an edge.
  - DELAY lasts DELAY cycles, then → PULSE. DELAY=0 gives zero cycles: the FSM passes directly from ARMED to PULSE.
  - PULSE lasts max(WIDTH,1) cycles with `glitch_en_o`=1, then PULSES_DONE is incremented.
    - If PULSES_DONE reaches COUNT: → IDLE, `done_o` pulses, done_sticky is set.
    - Otherwise → GAP.
  - GAP lasts max(GAP,1) cycles with `glitch_en_o`=0, then → PULSE.
- ABORT write in any non-IDLE state → IDLE on the next edge. `glitch_en_o` drops that same edge and `done_o` does not pulse. ARM and ABORT in the same write: ABORT wins.
- ARM written while not in IDLE is ignored.
- `glitch_en_o` is a registered output, high only in PULSE.

## Timing
- Wishbone handshake:
  - `ack_o` is registered and rises the cycle after `stb_i` is sampled high with `ack_o`=0.
  - `ack_o` is never high two consecutive cycles. The master must drop `stb_i` or present a new request.
  - A write takes effect on the same edge that raises `ack_o`.
- Software start: ARM sampled at edge T gives ARMED at T, DELAY at T+1, and first `glitch_en_o`=1 at edge T+1+DELAY.
- Train length: count×max(WIDTH,1) + (count−1)×max(GAP,1) cycles from the first rise of `glitch_en_o` to its final fall.
- `done_o` is high for the cycle that follows the last PULSE cycle.
- Counters are down-counters loaded on state entry. No wrap is possible. PULSES_DONE saturates at COUNT.
- Reset values:
  - `ack_o`=0, `dat_o`=0.
  - `glitch_en_o`=0, `busy_o`=0, `done_o`=0, `ready_o`=1.
  - All registers 0, FSM in IDLE.
- Reset asserted mid-train clears `glitch_en_o` immediately, asynchronously.

## Configuration
- `GLITCH_TRIG_SYNC_EN` defined:
  - `trig_i` passes through a 2-flop synchroniser and then an edge-detect register.
  - Edge recognised 3 edges after the `trig_i` transition is first sampled.
- Not defined:
  - `trig_i` is treated as already synchronous; only the edge-detect register remains.
  - Edge recognised 1 edge after the transition. All other timing is unchanged.

## Structure
- Shared package `glitch_pkg`:
  - Register address constants (CTRL=0 … PULSES_DONE=6).
  - CTRL bit indices.
  - FSM state encoding.
- One sub-module, `glitch_seq_fsm`: the FSM, counters and trigger edge detection. It receives latched parameters and arm/abort strobes.
- `glitch_seq_wb` holds the Wishbone decode and the register file.

## Test plan
- WIDTH=3, DELAY=5, COUNT=1, software ARM at edge T → `glitch_en_o` high for edges T+6..T+8; `done_o` high one cycle; CTRL read = 0x09, then 0x01.
- WIDTH=2, GAP=4, COUNT=3, DELAY=0 → three 2-cycle pulses separated by 4 low cycles; PULSES_DONE reads 3.
- TRIG_EXT=1, TRIG_FALL=1, `trig_i` held high at arm, falls 20 cycles later → DELAY starts at the macro-dependent latency; no start before the edge.
- ABORT during the second of COUNT=5 pulses → `glitch_en_o` low next cycle, `ready_o`=1, no `done_o`, PULSES_DONE=1.
- WIDTH write of 0x7F while busy → acked, WIDTH readback unchanged. Read of address 9 → ack with 0x00.
- `rst_ni` pulsed low mid-PULSE → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: register map, CTRL/STATUS bit
// positions, FSM state encoding and the duration-load helper.
package glitch_pkg;

    localparam logic [3:0] ADR_CTRL        = 4'd0;
    localparam logic [3:0] ADR_WIDTH       = 4'd1;
    localparam logic [3:0] ADR_DELAY_LO    = 4'd2;
    localparam logic [3:0] ADR_DELAY_HI    = 4'd3;
    localparam logic [3:0] ADR_GAP         = 4'd4;
    localparam logic [3:0] ADR_COUNT       = 4'd5;
    localparam logic [3:0] ADR_PULSES_DONE = 4'd6;

    localparam int CTRL_ARM       = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_TRIG_EXT  = 2;
    localparam int CTRL_TRIG_FALL = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_PULSE,
        ST_GAP
    } state_t;

    // Down-counter preload for a phase lasting max(v,1) cycles.
    function automatic logic [15:0] dur_load(input logic [15:0] v);
        return (v == 16'd0) ? 16'd0 : v - 16'd1;
    endfunction

endpackage

// File: rtl/glitch_seq_fsm.sv
// Glitch train FSM: trigger edge detection, phase counters and pulse counting.
// Optional trigger synchroniser enabled by GLITCH_TRIG_SYNC_EN.
module glitch_seq_fsm
    import glitch_pkg::*;
#(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int GAP_W   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               arm,
    input  logic               abort,
    input  logic               sticky_clr,
    input  logic               trig_i,
    input  logic               trig_ext,
    input  logic               trig_fall,
    input  logic [DELAY_W-1:0] delay,
    input  logic [WIDTH_W-1:0] width,
    input  logic [GAP_W-1:0]   gap,
    input  logic [COUNT_W-1:0] count,
    output logic               glitch_en,
    output logic               ready,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic               done_sticky,
    output logic [COUNT_W-1:0] pulses_done
);
    state_t             state_reg;
    logic [15:0]        cnt_reg;
    logic               trig_s;
    logic               trig_reg;
    logic               edge_reg;
    logic [COUNT_W-1:0] pulses_next;

`ifdef GLITCH_TRIG_SYNC_EN
    logic [1:0] sync_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_reg <= 2'b00;
        else         sync_reg <= {sync_reg[0], trig_i};
    end
    assign trig_s = sync_reg[1];
`else
    assign trig_s = trig_i;
`endif

    // Edge is registered so the FSM acts one edge after trig_s changes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            trig_reg <= trig_s;
            edge_reg <= trig_fall ? (trig_reg & ~trig_s) : (trig_s & ~trig_reg);
        end
    end

    assign pulses_next = pulses_done + COUNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 16'd0;
            pulses_done <= '0;
            glitch_en   <= 1'b0;
            ready       <= 1'b1;
            armed       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sticky_clr) done_sticky <= 1'b0;
            if (abort && state_reg != ST_IDLE) begin
                state_reg <= ST_IDLE;
                glitch_en <= 1'b0;
                ready     <= 1'b1;
                armed     <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (arm && count != '0) begin
                            state_reg   <= ST_ARMED;
                            ready       <= 1'b0;
                            armed       <= 1'b1;
                            pulses_done <= '0;
                            done_sticky <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (!trig_ext || edge_reg) begin
                            armed <= 1'b0;
                            busy  <= 1'b1;
                            if (delay == '0) begin
                                state_reg <= ST_PULSE;
                                cnt_reg   <= dur_load(16'(width));
                                glitch_en <= 1'b1;
                            end else begin
                                state_reg <= ST_DELAY;
                                cnt_reg   <= dur_load(16'(delay));
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (cnt_reg == 16'd0) begin
                            state_reg <= ST_PULSE;
                            cnt_reg   <= dur_load(16'(width));
                            glitch_en <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 16'd1;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_reg == 16'd0) begin
                            glitch_en   <= 1'b0;
                            pulses_done <= pulses_next;
                            if (pulses_next == count) begin
                                state_reg   <= ST_IDLE;
                                ready       <= 1'b1;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                done_sticky <= 1'b1;
                            end else begin
                                state_reg <= ST_GAP;
                                cnt_reg   <= dur_load(16'(gap));
                            end
                        end else begin
                            cnt_reg <= cnt_reg - 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_reg == 16'd0) begin
                            state_reg <= ST_PULSE;
                            cnt_reg   <= dur_load(16'(width));
                            glitch_en <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 16'd1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        glitch_en <= 1'b0;
                        ready     <= 1'b1;
                        armed     <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/glitch_seq_wb.sv
// Wishbone slave front end of the glitch sequencer: bus handshake, register
// file and read mux. Trigger synchroniser selected by GLITCH_TRIG_SYNC_EN.
module glitch_seq_wb
    import glitch_pkg::*;
#(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int GAP_W   = 8,
    parameter int COUNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [3:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic       trig_i,
    output logic       glitch_en_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o
);
    logic               req, wr, rd, ctrl_wr, cfg_wr;
    logic               arm, abort, sticky_clr;
    logic               trig_ext_reg, trig_fall_reg;
    logic [WIDTH_W-1:0] width_reg;
    logic [DELAY_W-1:0] delay_reg;
    logic [GAP_W-1:0]   gap_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [15:0]        delay_wide;
    logic               armed, done_sticky;
    logic [COUNT_W-1:0] pulses_done;
    logic [7:0]         rdata;

    assign req        = stb_i & ~ack_o;
    assign wr         = req & we_i;
    assign rd         = req & ~we_i;
    assign ctrl_wr    = wr & (adr_i == ADR_CTRL);
    assign abort      = ctrl_wr & dat_i[CTRL_ABORT];
    assign arm        = ctrl_wr & dat_i[CTRL_ARM] & ~dat_i[CTRL_ABORT];
    // Train parameters are frozen whenever a train is in progress.
    assign cfg_wr     = wr & ready_o;
    assign sticky_clr = rd & (adr_i == ADR_CTRL);
    assign delay_wide = 16'(delay_reg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_ext_reg  <= 1'b0;
            trig_fall_reg <= 1'b0;
            width_reg     <= '0;
            delay_reg     <= '0;
            gap_reg       <= '0;
            count_reg     <= '0;
        end else if (cfg_wr) begin
            case (adr_i)
                ADR_CTRL: begin
                    trig_ext_reg  <= dat_i[CTRL_TRIG_EXT];
                    trig_fall_reg <= dat_i[CTRL_TRIG_FALL];
                end
                ADR_WIDTH:    width_reg <= dat_i[WIDTH_W-1:0];
                ADR_DELAY_LO: delay_reg <= DELAY_W'({delay_wide[15:8], dat_i});
                ADR_DELAY_HI: delay_reg <= DELAY_W'({dat_i, delay_wide[7:0]});
                ADR_GAP:      gap_reg   <= dat_i[GAP_W-1:0];
                ADR_COUNT:    count_reg <= dat_i[COUNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (adr_i)
            ADR_CTRL:        rdata = {2'b00, trig_fall_reg, trig_ext_reg,
                                      done_sticky, busy_o, armed, ready_o};
            ADR_WIDTH:       rdata = 8'(width_reg);
            ADR_DELAY_LO:    rdata = delay_wide[7:0];
            ADR_DELAY_HI:    rdata = delay_wide[15:8];
            ADR_GAP:         rdata = 8'(gap_reg);
            ADR_COUNT:       rdata = 8'(count_reg);
            ADR_PULSES_DONE: rdata = 8'(pulses_done);
            default:         rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o <= 1'b0;
            dat_o <= 8'h00;
        end else begin
            ack_o <= req;
            dat_o <= rd ? rdata : 8'h00;
        end
    end

    glitch_seq_fsm #(
        .DELAY_W (DELAY_W),
        .WIDTH_W (WIDTH_W),
        .GAP_W   (GAP_W),
        .COUNT_W (COUNT_W)
    ) u_fsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .arm         (arm),
        .abort       (abort),
        .sticky_clr  (sticky_clr),
        .trig_i      (trig_i),
        .trig_ext    (trig_ext_reg),
        .trig_fall   (trig_fall_reg),
        .delay       (delay_reg),
        .width       (width_reg),
        .gap         (gap_reg),
        .count       (count_reg),
        .glitch_en   (glitch_en_o),
        .ready       (ready_o),
        .armed       (armed),
        .busy        (busy_o),
        .done        (done_o),
        .done_sticky (done_sticky),
        .pulses_done (pulses_done)
    );

endmodule

// File: tb/tb_glitch_seq_wb.sv
// Bench for glitch_seq_wb: directed scenarios plus random trains compared
// against an arithmetic model of the pulse train.
module tb_glitch_seq_wb;
`ifdef GLITCH_TRIG_SYNC_EN
    localparam int TRIG_LAT = 3;
`else
    localparam int TRIG_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic       trig = 1'b0;
    logic [3:0] adr = 4'd0;
    logic [7:0] wdat = 8'h00;
    logic [7:0] rdat;
    logic       ack, glitch_en, ready, busy, done;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glitch_seq_wb dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .stb_i       (stb),
        .we_i        (we),
        .adr_i       (adr),
        .dat_i       (wdat),
        .dat_o       (rdat),
        .ack_o       (ack),
        .trig_i      (trig),
        .glitch_en_o (glitch_en),
        .ready_o     (ready),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
        if (ack) begin @(posedge clk); #1; end
        stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        @(posedge clk); #1;
        check("wr_ack", ack, 1);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [7:0] d);
        if (ack) begin @(posedge clk); #1; end
        stb = 1'b1; we = 1'b0; adr = a;
        @(posedge clk); #1;
        check("rd_ack", ack, 1);
        d = rdat;
        stb = 1'b0;
    endtask

    task automatic setup(input int d, input int w, input int g, input int n);
        wb_write(4'd1, 8'(w));
        wb_write(4'd4, 8'(g));
        wb_write(4'd5, 8'(n));
        wb_write(4'd2, 8'(d));
        wb_write(4'd3, 8'(d >> 8));
    endtask

    // Model: r = cycles since the first pulse should rise.
    function automatic logic exp_en(input int r, input int wp, input int gp, input int n);
        if (r < 0) return 1'b0;
        if (r / (wp + gp) >= n) return 1'b0;
        return (r % (wp + gp)) < wp;
    endfunction

    // s = edge at which the FSM leaves ARMED.
    task automatic check_train(input int s, input int d, input int w, input int g,
                               input int n, input string tag);
        int wp, gp, len, stop, k, en_err, busy_err, done_err;
        logic [7:0] r;
        wp = (w == 0) ? 1 : w;
        gp = (g == 0) ? 1 : g;
        len = n * wp + (n - 1) * gp;
        stop = s + d + len + 3;
        en_err = 0; busy_err = 0; done_err = 0;
        while (cyc < stop) begin
            @(posedge clk); #1;
            k = cyc;
            if (glitch_en !== exp_en(k - s - d, wp, gp, n)) en_err++;
            if (busy !== (k >= s && k < s + d + len)) busy_err++;
            if (done !== (k == s + d + len)) done_err++;
        end
        check({tag, "_en_wave"}, en_err, 0);
        check({tag, "_busy_wave"}, busy_err, 0);
        check({tag, "_done_wave"}, done_err, 0);
        check({tag, "_ready"}, ready, 1);
        wb_read(4'd6, r);
        check({tag, "_pulses_done"}, r, n);
        $display("train %s d=%0d w=%0d g=%0d n=%0d en_err=%0d", tag, d, w, g, n, en_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int t, e, d, w, g, n, errs, p2;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", ack, 0);
        check("rst_dat", rdat, 0);
        check("rst_en", glitch_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 1);
        #17 rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(4'd0, r); check("rst_ctrl", r, 8'h01);
        for (int a = 1; a <= 6; a++) begin
            wb_read(4'(a), r); check("rst_reg", r, 0);
        end

        // Single pulse, software start
        setup(5, 3, 0, 1);
        wb_write(4'd0, 8'h01); t = cyc;
        check_train(t + 1, 5, 3, 0, 1, "single");
        wb_read(4'd0, r); check("ctrl_done", r, 8'h09);
        wb_read(4'd0, r); check("ctrl_cleared", r, 8'h01);

        // Three pulses, zero delay
        setup(0, 2, 4, 3);
        wb_write(4'd0, 8'h01); t = cyc;
        check_train(t + 1, 0, 2, 4, 3, "triple");

        // Random trains: software arm or external rising edge
        for (int i = 0; i < 12; i++) begin
            d = $urandom_range(0, 6);
            w = $urandom_range(0, 4);
            g = $urandom_range(0, 4);
            n = $urandom_range(1, 4);
            setup(d, w, g, n);
            if ($urandom_range(0, 1) == 1) begin
                wb_write(4'd0, 8'h04);
                wb_write(4'd0, 8'h05);
                repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
                trig = 1'b1; e = cyc + 1;
                check_train(e + TRIG_LAT, d, w, g, n, "rnd_ext");
                trig = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
            end else begin
                wb_write(4'd0, 8'h01); t = cyc;
                check_train(t + 1, d, w, g, n, "rnd_sw");
            end
        end

        // Falling-edge trigger with the line high at arm time
        trig = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        setup(2, 1, 1, 2);
        wb_write(4'd0, 8'h0C);
        wb_write(4'd0, 8'h0D);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy || glitch_en) errs++;
        end
        check("trig_early_start", errs, 0);
        wb_read(4'd0, r); check("trig_armed_status", r, 8'h32);
        trig = 1'b0; e = cyc + 1;
        check_train(e + TRIG_LAT, 2, 1, 1, 2, "trig_fall");

        // Abort during the second pulse
        setup(1, 3, 2, 5);
        wb_write(4'd0, 8'h01); t = cyc;
        p2 = t + 1 + 1 + 5;
        while (cyc < p2) begin @(posedge clk); #1; end
        check("abort_pre_en", glitch_en, 1);
        wb_write(4'd0, 8'h02);
        check("abort_en", glitch_en, 0);
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || glitch_en) errs++;
        end
        check("abort_no_done", errs, 0);
        wb_read(4'd6, r); check("abort_pulses_done", r, 1);

        // ARM together with ABORT, and ARM with COUNT=0: both stay idle
        wb_write(4'd0, 8'h03);
        @(posedge clk); #1;
        check("arm_abort_ready", ready, 1);
        wb_write(4'd5, 8'h00);
        wb_write(4'd0, 8'h01);
        @(posedge clk); #1;
        check("count0_ready", ready, 1);
        check("count0_busy", busy, 0);

        // Parameter write while busy is ignored; unmapped address reads 0
        setup(30, 2, 0, 1);
        wb_write(4'd0, 8'h01);
        wb_write(4'd1, 8'h7F);
        wb_read(4'd1, r); check("busy_width_kept", r, 2);
        wb_write(4'd9, 8'hFF);
        wb_read(4'd9, r); check("adr9_read", r, 0);
        wb_read(4'd2, r); check("delay_lo_read", r, 30);
        wb_write(4'd0, 8'h02);
        @(posedge clk); #1;
        check("busy_abort_ready", ready, 1);

        // Asynchronous reset in the middle of a pulse
        setup(0, 8, 0, 1);
        wb_write(4'd0, 8'h01);
        @(posedge clk); #1;
        check("mid_rst_pre_en", glitch_en, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_en", glitch_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_ack", ack, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(4'd1, r); check("mid_rst_width", r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
